// File: rtl/memory_unit_queued.sv
// Queued load/store unit: in-order request FIFO feeding a variable-latency data-memory port,
// with size/sign-adjusted load return, byte enables, misalignment trapping and a stats snapshot.
module memory_unit_queued #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int QUEUE_DEPTH  = 4,
    localparam int BYTES       = DATA_WIDTH / 8,
    localparam int OFS         = $clog2(BYTES),
    localparam int PTR_BITS    = $clog2(QUEUE_DEPTH)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_store,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDRESS_BITS-1:0] i_req_address,
    input  logic [DATA_WIDTH-1:0]   i_req_store_data,
    output logic                    o_resp_valid,
    output logic                    o_resp_store,
    output logic [ADDRESS_BITS-1:0] o_resp_address,
    output logic [DATA_WIDTH-1:0]   o_resp_data,
    output logic                    o_misaligned,
    output logic [PTR_BITS:0]       o_occupancy,
    output logic                    o_busy,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [ADDRESS_BITS-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0]   o_mem_store_data,
    output logic [BYTES-1:0]        o_mem_byte_en,
    input  logic                    i_mem_ready,
    input  logic                    i_mem_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_load_data,
    input  logic                    i_report,
    output logic [7:0]              o_rpt_core,
    output logic [1:0]              o_rpt_state,
    output logic [31:0]             o_rpt_cycle,
    output logic [31:0]             o_rpt_loads,
    output logic [31:0]             o_rpt_stores,
    output logic [31:0]             o_rpt_misaligned,
    output logic [31:0]             o_rpt_stalls
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic                    store;
        logic [1:0]              size;
        logic                    uns;
        logic [ADDRESS_BITS-1:0] addr;
        logic [DATA_WIDTH-1:0]   data;
    } entry_t;

    state_t                r_state, w_state_nx;
    entry_t                r_fifo [QUEUE_DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_BITS:0]     r_count;
    entry_t                w_head, w_new;
    logic                  w_accept, w_mis, w_push, w_pop;
    logic [OFS-1:0]        w_ofs;
    logic [OFS+2:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_lane, w_mask, w_ext;
    logic                  w_sign;

    logic                    r_resp_valid, r_resp_store, r_mis;
    logic [ADDRESS_BITS-1:0] r_resp_addr, r_mis_addr;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic [31:0]             r_cycle, r_loads, r_stores, r_mis_cnt, r_stalls;

    // Ready depends on count alone: a pop in the same cycle never frees a slot early.
    assign o_req_ready = (r_count < (PTR_BITS+1)'(QUEUE_DEPTH));
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_push      = w_accept & ~w_mis;
    assign w_pop       = (r_state == S_WAIT) & i_mem_valid;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_new       = '{store: i_req_store, size: i_req_size, uns: i_req_unsigned,
                           addr: i_req_address, data: i_req_store_data};
    assign w_ofs       = w_head.addr[OFS-1:0];
    assign w_shamt     = {w_ofs, 3'b000};

    always_comb begin
        w_mis = 1'b0;
        case (i_req_size)
            2'd1:    w_mis = i_req_address[0];
            2'd2:    w_mis = (i_req_address[1:0] != 2'b00);
            2'd3:    w_mis = (DATA_WIDTH == 32) || (i_req_address[2:0] != 3'b000);
            default: w_mis = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nx = S_ISSUE;
            S_ISSUE: if (i_mem_ready) w_state_nx = S_WAIT;
            S_WAIT:  if (i_mem_valid)
                         w_state_nx = (r_count > (PTR_BITS+1)'(1) || w_push) ? S_ISSUE : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // The head only advances on a pop in WAIT, so these stay stable for the whole ISSUE stall.
    always_comb begin
        o_mem_read       = 1'b0;
        o_mem_write      = 1'b0;
        o_mem_address    = '0;
        o_mem_store_data = '0;
        o_mem_byte_en    = '0;
        if (r_state == S_ISSUE) begin
            o_mem_read       = ~w_head.store;
            o_mem_write      = w_head.store;
            o_mem_address    = {w_head.addr[ADDRESS_BITS-1:OFS], {OFS{1'b0}}};
            o_mem_store_data = w_head.data << w_shamt;
            for (int b = 0; b < BYTES; b++)
                o_mem_byte_en[b] = ~w_head.store ||
                                   ((b >= int'(w_ofs)) && (b < int'(w_ofs) + (1 << int'(w_head.size))));
        end
    end

    always_comb begin
        w_lane = i_mem_load_data >> w_shamt;
        w_mask = '1;
        w_sign = w_lane[DATA_WIDTH-1];
        case (w_head.size)
            2'd0:    begin w_mask = DATA_WIDTH'(8'hFF);         w_sign = w_lane[7];  end
            2'd1:    begin w_mask = DATA_WIDTH'(16'hFFFF);      w_sign = w_lane[15]; end
            2'd2:    begin w_mask = DATA_WIDTH'(32'hFFFF_FFFF); w_sign = w_lane[31]; end
            default: begin w_mask = '1;                         w_sign = w_lane[DATA_WIDTH-1]; end
        endcase
        w_ext = (w_lane & w_mask) | ((w_sign & ~w_head.uns) ? ~w_mask : '0);
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_new;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_store <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_data  <= '0;
            r_mis        <= 1'b0;
            r_mis_addr   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_count      <= r_count + (PTR_BITS+1)'(w_push) - (PTR_BITS+1)'(w_pop);
            r_resp_valid <= w_pop;
            r_mis        <= w_accept & w_mis;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_resp_store <= w_head.store;
                r_resp_addr  <= w_head.addr;
                r_resp_data  <= w_head.store ? '0 : w_ext;
            end
            if (w_accept & w_mis) r_mis_addr <= i_req_address;
        end
    end

    // Stats wrap freely; the report outputs are a snapshot taken on cycles with i_report high.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cycle          <= '0;
            r_loads          <= '0;
            r_stores         <= '0;
            r_mis_cnt        <= '0;
            r_stalls         <= '0;
            o_rpt_core       <= '0;
            o_rpt_state      <= '0;
            o_rpt_cycle      <= '0;
            o_rpt_loads      <= '0;
            o_rpt_stores     <= '0;
            o_rpt_misaligned <= '0;
            o_rpt_stalls     <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_push & ~i_req_store)              r_loads   <= r_loads + 32'd1;
            if (w_push & i_req_store)               r_stores  <= r_stores + 32'd1;
            if (w_accept & w_mis)                   r_mis_cnt <= r_mis_cnt + 32'd1;
            if (r_state == S_ISSUE && !i_mem_ready) r_stalls  <= r_stalls + 32'd1;
            if (i_report) begin
                o_rpt_core       <= 8'(CORE);
                o_rpt_state      <= r_state;
                o_rpt_cycle      <= r_cycle;
                o_rpt_loads      <= r_loads;
                o_rpt_stores     <= r_stores;
                o_rpt_misaligned <= r_mis_cnt;
                o_rpt_stalls     <= r_stalls;
            end
        end
    end

    assign o_resp_valid   = r_resp_valid;
    assign o_resp_store   = r_resp_store;
    assign o_resp_data    = r_resp_data;
    assign o_misaligned   = r_mis;
    assign o_resp_address = r_mis ? r_mis_addr : r_resp_addr;
    assign o_occupancy    = r_count;
    assign o_busy         = (r_count != '0) || (r_state != S_IDLE);
endmodule

// File: tb/tb_memory_unit_queued.sv
// Scoreboard bench for memory_unit_queued: byte-level reference memory, randomized memory timing.
module tb_memory_unit_queued;
    localparam int DW = 32;
    localparam int AB = 20;
    localparam int BY = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_req_valid, i_req_store, i_req_unsigned;
    logic [1:0]    i_req_size;
    logic [AB-1:0] i_req_address;
    logic [DW-1:0] i_req_store_data;
    logic          o_req_ready, o_resp_valid, o_resp_store, o_misaligned, o_busy;
    logic [AB-1:0] o_resp_address, o_mem_address;
    logic [DW-1:0] o_resp_data, o_mem_store_data;
    logic [2:0]    o_occupancy;
    logic          o_mem_read, o_mem_write;
    logic [BY-1:0] o_mem_byte_en;
    logic          i_mem_ready, i_mem_valid, i_report;
    logic [DW-1:0] i_mem_load_data;
    logic [7:0]    o_rpt_core;
    logic [1:0]    o_rpt_state;
    logic [31:0]   o_rpt_cycle, o_rpt_loads, o_rpt_stores, o_rpt_misaligned, o_rpt_stalls;

    memory_unit_queued dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_store(i_req_store),
        .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned), .i_req_address(i_req_address),
        .i_req_store_data(i_req_store_data),
        .o_resp_valid(o_resp_valid), .o_resp_store(o_resp_store), .o_resp_address(o_resp_address),
        .o_resp_data(o_resp_data), .o_misaligned(o_misaligned), .o_occupancy(o_occupancy), .o_busy(o_busy),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_address(o_mem_address),
        .o_mem_store_data(o_mem_store_data), .o_mem_byte_en(o_mem_byte_en),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_load_data(i_mem_load_data),
        .i_report(i_report), .o_rpt_core(o_rpt_core), .o_rpt_state(o_rpt_state),
        .o_rpt_cycle(o_rpt_cycle), .o_rpt_loads(o_rpt_loads), .o_rpt_stores(o_rpt_stores),
        .o_rpt_misaligned(o_rpt_misaligned), .o_rpt_stalls(o_rpt_stalls)
    );

    typedef struct {logic store; logic [AB-1:0] addr; logic [DW-1:0] data;} resp_t;
    typedef struct {logic wr; logic [AB-1:0] addr; logic [BY-1:0] be; logic [DW-1:0] data;} mreq_t;

    resp_t         exp_resp[$];
    mreq_t         exp_mreq[$];
    logic [AB-1:0] exp_mis[$];
    logic [7:0]    ref_mem [64];
    logic [7:0]    dev_mem [64];

    int n_tests = 0, n_fail = 0, n_resp_seen = 0;
    int m_loads = 0, m_stores = 0, m_mis = 0;
    bit auto_mem = 1'b1, hold_resp = 1'b0, pend = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name, input string got, input string need);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %s, need %s", name, got, need);
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ref_mem[a+i] = w[8*i +: 8];
            dev_mem[a+i] = w[8*i +: 8];
        end
    endtask

    function automatic logic [DW-1:0] ref_load(input int a, input int sz, input logic un);
        logic [DW-1:0] v = '0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) v |= DW'(ref_mem[a+i]) << (8*i);
        if (!un && v[8*n-1])
            for (int k = 8*n; k < DW; k++) v[k] = 1'b1;
        return v;
    endfunction

    // Reference: decide acceptance outcome and the memory traffic/response it must produce.
    task automatic model_accept(input logic st, input logic [1:0] sz, input logic un, input logic [AB-1:0] a,
                                input logic [DW-1:0] d, input bit lit, input logic [DW-1:0] lit_rd,
                                input logic [BY-1:0] lit_be, input logic [DW-1:0] lit_wd);
        resp_t r;
        mreq_t m;
        int n = 1 << sz;
        int ofs = int'(a) % 4;
        if (sz == 2'd3 || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && ofs != 0)) begin
            exp_mis.push_back(a);
            m_mis++;
            return;
        end
        r.store = st;
        r.addr  = a;
        r.data  = st ? '0 : (lit ? lit_rd : ref_load(int'(a), int'(sz), un));
        m.wr    = st;
        m.addr  = a - AB'(ofs);
        m.be    = st ? BY'(((1 << n) - 1) << ofs) : '1;
        m.data  = st ? (d << (8*ofs)) : '0;
        if (lit && st) begin
            m.be   = lit_be;
            m.data = lit_wd;
        end
        if (st) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a)+i] = d[8*i +: 8];
            m_stores++;
        end else m_loads++;
        exp_resp.push_back(r);
        exp_mreq.push_back(m);
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un, input logic [AB-1:0] a,
                          input logic [DW-1:0] d, input bit lit = 1'b0, input logic [DW-1:0] lit_rd = '0,
                          input logic [BY-1:0] lit_be = '0, input logic [DW-1:0] lit_wd = '0);
        bit ok = 1'b0;
        i_req_valid = 1'b1; i_req_store = st; i_req_size = sz; i_req_unsigned = un;
        i_req_address = a; i_req_store_data = d;
        for (int t = 0; t < 200; t++) begin
            if (o_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) model_accept(st, sz, un, a, d, lit, lit_rd, lit_be, lit_wd);
        else fail_evt("req_ready_timeout", "no ready", "ready within 200 cycles");
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_resp.size() == 0 && exp_mis.size() == 0 && !o_busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail_evt("drain_timeout", $sformatf("%0d responses pending", exp_resp.size()), "0 pending");
    endtask

    // Memory responder: random accept, random response delay, occasional stray mem_valid.
    initial begin
        int dly = 0;
        logic [AB-1:0] p_addr = '0;
        logic p_rd = 1'b0;
        logic [DW-1:0] w;
        mreq_t e;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_load_data = '0;
        forever begin
            @(negedge clk);
            i_mem_valid = 1'b0;
            i_mem_ready = 1'b0;
            if (pend) begin
                if (!hold_resp) begin
                    if (dly == 0) begin
                        w = $urandom;
                        if (p_rd)
                            for (int b = 0; b < BY; b++)
                                w[8*b +: 8] = (int'(p_addr) + b < 64) ? dev_mem[int'(p_addr)+b] : 8'h00;
                        i_mem_load_data = w;
                        i_mem_valid = 1'b1;
                        pend = 1'b0;
                    end else dly--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                i_mem_load_data = $urandom;
                i_mem_valid = 1'b1;
            end
            if (!pend && (o_mem_read || o_mem_write) && auto_mem && $urandom_range(0, 2) != 0) begin
                i_mem_ready = 1'b1;
                if (exp_mreq.size() == 0) fail_evt("mem_unexpected", "memory request", "none");
                else begin
                    e = exp_mreq.pop_front();
                    check("mem_write", 64'(o_mem_write), 64'(e.wr));
                    check("mem_read", 64'(o_mem_read), 64'(!e.wr));
                    check("mem_address", 64'(o_mem_address), 64'(e.addr));
                    check("mem_byte_en", 64'(o_mem_byte_en), 64'(e.be));
                    if (e.wr) check("mem_store_data", 64'(o_mem_store_data), 64'(e.data));
                end
                if (o_mem_write)
                    for (int b = 0; b < BY; b++)
                        if (o_mem_byte_en[b] && int'(o_mem_address) + b < 64)
                            dev_mem[int'(o_mem_address)+b] = o_mem_store_data[8*b +: 8];
                p_addr = o_mem_address;
                p_rd   = o_mem_read;
                dly    = $urandom_range(0, 3);
                pend   = 1'b1;
            end
        end
    end

    // Monitor: every response/trap pulse must match the next scoreboard entry.
    initial begin
        resp_t r;
        logic [AB-1:0] ma;
        forever begin
            @(negedge clk);
            if (o_misaligned) begin
                if (exp_mis.size() == 0) fail_evt("misaligned_unexpected", "pulse", "none");
                else begin
                    ma = exp_mis.pop_front();
                    check("misaligned_address", 64'(o_resp_address), 64'(ma));
                end
            end
            if (o_resp_valid) begin
                n_resp_seen++;
                if (exp_resp.size() == 0) fail_evt("resp_unexpected", "resp_valid", "none");
                else begin
                    r = exp_resp.pop_front();
                    check("resp_store", 64'(o_resp_store), 64'(r.store));
                    check("resp_data", 64'(o_resp_data), 64'(r.data));
                    if (!o_misaligned) check("resp_address", 64'(o_resp_address), 64'(r.addr));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got time limit, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bit ok;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            dev_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst = 1'b1; i_report = 1'b0;
        i_req_valid = 1'b0; i_req_store = 1'b0; i_req_size = '0; i_req_unsigned = 1'b0;
        i_req_address = '0; i_req_store_data = '0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(o_req_ready), 64'd1);
        check("reset_occupancy", 64'(o_occupancy), 64'd0);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_resp_valid", 64'(o_resp_valid), 64'd0);
        check("reset_misaligned", 64'(o_misaligned), 64'd0);
        check("reset_mem_req", 64'({o_mem_read, o_mem_write, o_mem_byte_en}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        set_word('h10, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 20'h00010, '0, 1'b1, 32'hDEADBEEF);
        wait_drain();

        set_word('h10, 32'h80FF1234);
        do_req(1'b0, 2'd0, 1'b0, 20'h00013, '0, 1'b1, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 20'h00013, '0, 1'b1, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 20'h00012, '0, 1'b1, 32'hFFFF80FF);
        wait_drain();

        do_req(1'b1, 2'd1, 1'b0, 20'h00006, 32'h0000ABCD, 1'b1, '0, 4'b1100, 32'hABCD0000);
        wait_drain();

        do_req(1'b0, 2'd2, 1'b0, 20'h00002, '0);
        check("t4_misaligned", 64'(o_misaligned), 64'd1);
        check("t4_resp_address", 64'(o_resp_address), 64'h2);
        check("t4_occupancy", 64'(o_occupancy), 64'd0);
        check("t4_no_mem_read", 64'(o_mem_read), 64'd0);
        wait_drain();

        auto_mem = 1'b0;
        for (int k = 0; k < 4; k++) do_req(1'b0, 2'd2, 1'b0, AB'(4*k), '0);
        check("t5_full_ready", 64'(o_req_ready), 64'd0);
        check("t5_occupancy", 64'(o_occupancy), 64'd4);
        i_req_valid = 1'b1; i_req_address = 20'h00010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_held_ready", 64'(o_req_ready), 64'd0);
        end
        auto_mem = 1'b1;
        do_req(1'b0, 2'd2, 1'b1, 20'h00010, '0);
        wait_drain();

        hold_resp = 1'b1;
        for (int k = 0; k < 3; k++) do_req(1'b0, 2'd1, 1'b0, AB'(8*k + 2), '0);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (pend) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_evt("t6_issue_timeout", "no issue", "issue within 100 cycles");
        @(negedge clk);
        check("t6_occupancy_wait", 64'(o_occupancy), 64'd3);
        rst = 1'b1;
        exp_resp.delete(); exp_mreq.delete(); exp_mis.delete();
        m_loads = 0; m_stores = 0; m_mis = 0;
        @(negedge clk);
        rst = 1'b0;
        snap = n_resp_seen;
        hold_resp = 1'b0;
        check("t6_occupancy", 64'(o_occupancy), 64'd0);
        check("t6_busy", 64'(o_busy), 64'd0);
        repeat (8) @(negedge clk);
        check("t6_no_resp", 64'(n_resp_seen - snap), 64'd0);
        check("t6_idle_busy", 64'(o_busy), 64'd0);

        for (int k = 0; k < 400; k++) begin
            do_req(1'($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)), 1'($urandom),
                   AB'($urandom_range(0, 63)), DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        check("final_mreq_empty", 64'(exp_mreq.size()), 64'd0);

        i_report = 1'b1;
        @(negedge clk);
        i_report = 1'b0;
        check("stat_loads", 64'(o_rpt_loads), 64'(m_loads));
        check("stat_stores", 64'(o_rpt_stores), 64'(m_stores));
        check("stat_misaligned", 64'(o_rpt_misaligned), 64'(m_mis));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
